// File: rtl/rv32imf_apu_arbiter_if.sv
// Bundles the requester-side and FPU-side APU signals of rv32imf_apu_arbiter.
// Handshake: a transfer happens on a clock edge where the initiator's valid
// (req_i / apu_req_o) and the target's ready (gnt_o / apu_gnt_i) are both 1.
// While valid is high and ready is low, the initiator holds valid and payload.
// Result side: rvalid has no ready; the consumer must always accept.
interface rv32imf_apu_arbiter_if #(
  parameter int NREQ     = 2,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
);
  // requester side
  logic [NREQ-1:0]          req_i;
  logic [NREQ-1:0]          gnt_o;
  logic [NREQ*NARGS*32-1:0] operands_i;
  logic [NREQ*WOP-1:0]      op_i;
  logic [NREQ*NDSFLAGS-1:0] flags_i;
  logic [NREQ-1:0]          rvalid_o;
  logic [31:0]              rdata_o;
  logic [NUSFLAGS-1:0]      rflags_o;
  // FPU side
  logic                     apu_req_o;
  logic                     apu_gnt_i;
  logic [NARGS*32-1:0]      apu_operands_o;
  logic [WOP-1:0]           apu_op_o;
  logic [NDSFLAGS-1:0]      apu_flags_o;
  logic                     apu_rvalid_i;
  logic [31:0]              apu_rdata_i;
  logic [NUSFLAGS-1:0]      apu_rflags_i;

  // arbiter view
  modport slave (
    input  req_i, operands_i, op_i, flags_i,
    input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
    output gnt_o, rvalid_o, rdata_o, rflags_o,
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

  // environment view (requesters + FPU)
  modport master (
    output req_i, operands_i, op_i, flags_i,
    output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
    input  gnt_o, rvalid_o, rdata_o, rflags_o,
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );
endinterface

// File: rtl/rv32imf_apu_arbiter.sv
// Round-robin arbiter sharing one FPU between NREQ APU requesters.
// An in-order ID FIFO remembers the issuer of every outstanding op so that
// results (which return in issue order) are routed back without added latency.
// Optional macro RV32IMF_APU_ARB_PERF_EN adds issue/stall performance counters.
module rv32imf_apu_arbiter #(
  parameter int NREQ     = 2,
  parameter int DEPTH    = 4,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rv32imf_apu_arbiter_if.slave  bus,
`ifdef RV32IMF_APU_ARB_PERF_EN
  output logic [NREQ*32-1:0]    perf_issue_o,
  output logic [31:0]           perf_stall_o,
`endif
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int SW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SW-1:0] r_rr_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [SW-1:0] r_fifo [DEPTH];
  logic          r_err;

  logic [SW-1:0] w_sel;
  logic          w_found;
  int            w_idx;
  logic          w_can_issue;
  logic          w_apu_req;
  logic          w_hs;
  logic          w_pop;
  logic [SW-1:0] w_head;

  // Rotating priority scan starting at r_rr_ptr; requester 0 when idle.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NREQ;
      if (!w_found && bus.req_i[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx[SW-1:0];
      end
    end
  end

  // No full bypass: a pop in the same cycle does not unblock issue.
  assign w_can_issue = (r_count < CW'(DEPTH));
  assign w_apu_req   = w_can_issue & (|bus.req_i);
  assign w_hs        = w_apu_req & bus.apu_gnt_i;
  assign w_pop       = bus.apu_rvalid_i & (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];

  assign bus.apu_req_o      = w_apu_req;
  assign bus.apu_operands_o = bus.operands_i[int'(w_sel)*NARGS*32 +: NARGS*32];
  assign bus.apu_op_o       = bus.op_i[int'(w_sel)*WOP +: WOP];
  assign bus.apu_flags_o    = bus.flags_i[int'(w_sel)*NDSFLAGS +: NDSFLAGS];
  assign bus.gnt_o          = w_hs  ? (NREQ'(1) << w_sel)  : '0;
  assign bus.rvalid_o       = w_pop ? (NREQ'(1) << w_head) : '0;
  assign bus.rdata_o        = bus.apu_rdata_i;
  assign bus.rflags_o       = bus.apu_rflags_i;

  assign busy_o = (r_count != '0);
  assign err_o  = r_err;

  // ID FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

  // Pointers, occupancy, round-robin pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rr_ptr <= (w_sel == SW'(NREQ - 1)) ? '0 : w_sel + SW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.apu_rvalid_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef RV32IMF_APU_ARB_PERF_EN
  logic [NREQ*32-1:0] r_perf_issue;
  logic [31:0]        r_perf_stall;

  // Per-requester handshake counts and stalled-request cycles, wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs) begin
        r_perf_issue[int'(w_sel)*32 +: 32] <= r_perf_issue[int'(w_sel)*32 +: 32] + 32'd1;
      end
      if ((|bus.req_i) && !w_hs) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_issue_o = r_perf_issue;
  assign perf_stall_o = r_perf_stall;
`endif
endmodule

// File: tb/tb_rv32imf_apu_arbiter.sv
// Bench for rv32imf_apu_arbiter: directed scenarios with an expected-issuer queue.
module tb_rv32imf_apu_arbiter;
  logic clk;
  logic rst_ni;
  logic busy;
  logic err;
`ifdef RV32IMF_APU_ARB_PERF_EN
  logic [63:0] perf_issue;
  logic [31:0] perf_stall;
`endif

  logic [95:0] ops0, ops1;
  logic [5:0]  op0, op1;
  logic [14:0] fl0, fl1;
  logic [7:0]  exp_q[$];
  logic [7:0]  e;
  logic [31:0] d;
  logic [1:0]  one = 2'b01;
  int n_checks = 0;
  int n_pass   = 0;

  rv32imf_apu_arbiter_if #(.NREQ(2), .NARGS(3), .WOP(6), .NDSFLAGS(15), .NUSFLAGS(5)) bus ();

  rv32imf_apu_arbiter #(.NREQ(2), .DEPTH(4), .NARGS(3), .WOP(6), .NDSFLAGS(15), .NUSFLAGS(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave),
`ifdef RV32IMF_APU_ARB_PERF_EN
    .perf_issue_o (perf_issue),
    .perf_stall_o (perf_stall),
`endif
    .busy_o (busy),
    .err_o  (err)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.operands_i = {ops1, ops0};
  assign bus.op_i       = {op1, op0};
  assign bus.flags_i    = {fl1, fl0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    bus.req_i        = req;
    bus.apu_gnt_i    = gnt;
    bus.apu_rvalid_i = rv;
    bus.apu_rdata_i  = rd;
    bus.apu_rflags_i = rd[4:0];
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (bus.gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", bus.rvalid_o); else n_pass++;
    n_checks++; if (bus.apu_req_o !== 1'b0) $display("FAIL reset_apu_req: got %b want 0", bus.apu_req_o); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 32'd0);
    n_checks++; if (bus.gnt_o !== 2'b01) $display("FAIL single_gnt: got %b want 01", bus.gnt_o); else n_pass++;
    n_checks++; if (bus.apu_operands_o !== ops0) $display("FAIL single_operands: got %h want %h", bus.apu_operands_o, ops0); else n_pass++;
    n_checks++; if (bus.apu_op_o !== op0) $display("FAIL single_op: got %h want %h", bus.apu_op_o, op0); else n_pass++;
    exp_q.push_back(8'd0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    tick();
    d = $urandom;
    drive(2'b00, 1'b0, 1'b1, d);
    e = exp_q.pop_front();
    n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL single_rvalid: got %b want %b", bus.rvalid_o, one << e); else n_pass++;
    n_checks++; if (bus.rdata_o !== d) $display("FAIL single_rdata: got %h want %h", bus.rdata_o, d); else n_pass++;
    n_checks++; if (bus.rflags_o !== d[4:0]) $display("FAIL single_rflags: got %h want %h", bus.rflags_o, d[4:0]); else n_pass++;
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 32'd0);
      n_checks++; if (bus.gnt_o !== seq[i]) $display("FAIL rr_gnt%0d: got %b want %b", i, bus.gnt_o, seq[i]); else n_pass++;
      n_checks++; if (bus.apu_op_o !== ((i % 2 == 0) ? op0 : op1)) $display("FAIL rr_op%0d: got %h", i, bus.apu_op_o); else n_pass++;
      exp_q.push_back(8'(i % 2));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive(2'b00, 1'b0, 1'b1, d);
      e = exp_q.pop_front();
      n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL rr_rvalid%0d: got %b want %b", i, bus.rvalid_o, one << e); else n_pass++;
      n_checks++; if (bus.rdata_o !== d) $display("FAIL rr_rdata%0d: got %h want %h", i, bus.rdata_o, d); else n_pass++;
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 1'b1, 1'b0, 32'd0);
      n_checks++; if (bus.gnt_o !== 2'b01) $display("FAIL full_gnt%0d: got %b want 01", i, bus.gnt_o); else n_pass++;
      exp_q.push_back(8'd0);
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, 32'd0);
    n_checks++; if (bus.apu_req_o !== 1'b0) $display("FAIL full_block_req: got %b want 0", bus.apu_req_o); else n_pass++;
    n_checks++; if (bus.gnt_o !== 2'b00) $display("FAIL full_block_gnt: got %b want 00", bus.gnt_o); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy); else n_pass++;
    tick();
    d = $urandom;
    drive(2'b01, 1'b1, 1'b1, d);
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt_o !== 2'b00) $display("FAIL full_no_bypass: got %b want 00", bus.gnt_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL full_rvalid: got %b want %b", bus.rvalid_o, one << e); else n_pass++;
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'd0);
    n_checks++; if (bus.gnt_o !== 2'b01) $display("FAIL full_resume: got %b want 01", bus.gnt_o); else n_pass++;
    exp_q.push_back(8'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive(2'b00, 1'b0, 1'b1, d);
      e = exp_q.pop_front();
      n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL full_drain%0d: got %b want %b", i, bus.rvalid_o, one << e); else n_pass++;
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (busy !== 1'b0) $display("FAIL full_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b0, 1'b0, 32'd0);
      n_checks++; if (bus.gnt_o !== 2'b00) $display("FAIL stall_gnt%0d: got %b want 00", i, bus.gnt_o); else n_pass++;
      n_checks++; if (bus.apu_req_o !== 1'b1) $display("FAIL stall_req%0d: got %b want 1", i, bus.apu_req_o); else n_pass++;
      n_checks++; if (bus.apu_operands_o !== ops1) $display("FAIL stall_operands%0d: got %h want %h", i, bus.apu_operands_o, ops1); else n_pass++;
      n_checks++; if (bus.apu_flags_o !== fl1) $display("FAIL stall_flags%0d: got %h want %h", i, bus.apu_flags_o, fl1); else n_pass++;
      tick();
    end
    drive(2'b10, 1'b1, 1'b0, 32'd0);
    n_checks++; if (bus.gnt_o !== 2'b10) $display("FAIL stall_release: got %b want 10", bus.gnt_o); else n_pass++;
    exp_q.push_back(8'd1);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'd0);
    n_checks++; if (bus.gnt_o !== 2'b01) $display("FAIL stall_rr_wrap: got %b want 01", bus.gnt_o); else n_pass++;
    exp_q.push_back(8'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      drive(2'b00, 1'b0, 1'b1, d);
      e = exp_q.pop_front();
      n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL stall_drain%0d: got %b want %b", i, bus.rvalid_o, one << e); else n_pass++;
      tick();
    end
  endtask

  task automatic test_err();
    do_reset();
    d = $urandom;
    drive(2'b00, 1'b0, 1'b1, d);
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL err_rvalid: got %b want 00", bus.rvalid_o); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL err_before: got %b want 0", err); else n_pass++;
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL err_no_pop: got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    n_checks++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_push_pop();
    do_reset();
    drive(2'b11, 1'b1, 1'b0, 32'd0);
    exp_q.push_back(8'd0);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'd0);
    exp_q.push_back(8'd1);
    tick();
    d = $urandom;
    drive(2'b11, 1'b1, 1'b1, d);
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt_o !== 2'b01) $display("FAIL pp_gnt: got %b want 01", bus.gnt_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL pp_rvalid: got %b want %b", bus.rvalid_o, one << e); else n_pass++;
    exp_q.push_back(8'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      drive(2'b00, 1'b0, 1'b1, d);
      e = exp_q.pop_front();
      n_checks++; if (bus.rvalid_o !== (one << e)) $display("FAIL pp_drain%0d: got %b want %b", i, bus.rvalid_o, one << e); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL pp_busy%0d: got %b want 1", i, busy); else n_pass++;
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (busy !== 1'b0) $display("FAIL pp_idle: got %b want 0", busy); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL pp_queue: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

`ifdef RV32IMF_APU_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b1, 1'b0, 32'd0);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    n_checks++; if (perf_issue[31:0] !== 32'd3) $display("FAIL perf_issue0: got %0d want 3", perf_issue[31:0]); else n_pass++;
    n_checks++; if (perf_issue[63:32] !== 32'd0) $display("FAIL perf_issue1: got %0d want 0", perf_issue[63:32]); else n_pass++;
    n_checks++; if (perf_stall !== 32'd0) $display("FAIL perf_stall: got %0d want 0", perf_stall); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b1, 32'd0);
      tick();
    end
  endtask
`endif

  // sequence of scenarios and final report
  initial begin
    ops0 = {$urandom, $urandom, $urandom};
    ops1 = {$urandom, $urandom, $urandom};
    op0  = 6'($urandom_range(0, 31));
    op1  = 6'($urandom_range(32, 63));
    fl0  = 15'($urandom_range(0, 16383));
    fl1  = 15'($urandom_range(16384, 32767));
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_stall();
    test_err();
    test_push_pop();
`ifdef RV32IMF_APU_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
